pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline control for the five-stage MIPS datapath, driving the EN/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. Consumes the registers' outputs (load-use detection, branch resolution, memory requests, halt) and the cache handshakes (ihit/dhit). Holds a completed data access across instruction-fetch waits, buffering the loaded word so MEM/WB captures it when the pipe advances. Latches halt to freeze the machine.

## Interface
- No parameters.
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- dload_i  in  32  data cache read word
- id_rs, id_rt  in  5 each  source registers of instruction in IF/ID
- id_uses_rt  in  1  IF/ID instruction reads rt
- ex_dREN, ex_rfWEN  in  1 each  ID/EX outputs
- ex_wsel  in  5  ID/EX write-select output
- mem_dREN, mem_dWEN  in  1 each  EX/MEM outputs
- br_mispredict  in  1  branch/jump resolved wrong in EX (level, held while EX held)
- wb_halt  in  1  MEM/WB halt output
- pc_en  out  1  PC register enable
- ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush  out  1 each  pipe register controls; a flush clears the register on the edge where its EN is also 1
- dmem_req_en  out  1  gates dREN/dWEN to the data cache
- dload_o  out  32  word presented to MEM/WB dmemload_i
- halted  out  1  machine halted

## Operation
- States: RUN, DHELD, HALTED. Reset -> RUN.
- mem_pending = mem_dREN | mem_dWEN.
- advance = ihit & (~mem_pending | dhit | state==DHELD) & state!=HALTED.
- lu (load-use) = ex_dREN & ex_rfWEN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
- advance=0: every EN and flush 0, pc_en 0.
- advance=1, priority order:
  - br_mispredict: all EN 1, pc_en 1, ifid_flush 1, idex_flush 1 (mispredict overrides lu).
  - lu: pc_en 0, ifid_en 0, idex_en 1, idex_flush 1 (bubble), exmem_en 1, memwb_en 1.
  - else: all EN 1, pc_en 1, no flush.
- exmem_flush and memwb_flush are 0 in every state.
- RUN -> DHELD: dhit & mem_pending & ~ihit; latch dload_i into dbuf.
- DHELD -> RUN: ihit (pipe advances this cycle).
- RUN/DHELD -> HALTED: wb_halt & advance. HALTED is sticky until RST.
- dload_o = dbuf in DHELD, else dload_i.
- dmem_req_en = 0 in DHELD and HALTED, else 1. This prevents reissue of a completed access.
- halted = (state==HALTED).
- Simultaneous dhit & ihit in RUN: advance, stay RUN, no latch.

## Timing
- Control outputs are combinational from state and inputs; the state/dbuf update takes one edge.
- Reset values: state RUN, dbuf 0, halted 0, dmem_req_en 1. With all inputs 0, every EN, flush and pc_en is 0.
- dbuf is valid from the cycle after the dhit until the advancing edge.
- RST while in DHELD: return to RUN next edge, dbuf cleared, and the held access is reissued.
- Halt: on the edge where wb_halt & advance, MEM/WB advances once more. From the next cycle, all EN are 0 and halted is 1.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with state!=HALTED & (~advance | lu).
  - flush_cnt increments each advance with br_mispredict.
  - Both wrap at 2^32, reset to 0, and freeze in HALTED.
- Undefined: no counter ports or logic. Control behaviour is identical either way.

## Test plan
- ihit=1, no hazards, 10 cycles -> pc_en and all EN 1 every cycle, no flush.
- ex_dREN=1, ex_rfWEN=1, ex_wsel=5, id_rs=5, ihit=1 -> pc_en 0, ifid_en 0, idex_flush 1. With ex_wsel=0 instead -> no stall.
- mem_dREN=1, dhit=1, ihit=0, dload_i=0xDEADBEEF; next cycle dload_i=0, ihit=1 -> DHELD, dmem_req_en 0, dload_o 0xDEADBEEF, all EN 1, then RUN.
- br_mispredict=1 together with a load-use match, ihit=1 -> ifid_flush 1, idex_flush 1, pc_en 1.
- wb_halt=1, ihit=1 -> halted 1 next cycle, all EN 0 for 20 cycles regardless of ihit/dhit; RST -> RUN, halted 0.
- With PIPE_CTRL_PERF_EN: 3 ihit-low cycles plus 1 mispredict -> stall_cnt 3, flush_cnt 1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central hazard/stall/flush control for the five-stage MIPS pipeline.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
//
// state  | meaning
// RUN    | normal operation; data cache access issued from MEM
// DHELD  | data access done, waiting on ifetch; loaded word held in dbuf
// HALTED | halt retired through WB; machine frozen until RST
module pipe_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] dload_i,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_dREN,
  input  logic        ex_rfWEN,
  input  logic [4:0]  ex_wsel,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        br_mispredict,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        dmem_req_en,
  output logic [31:0] dload_o,
  output logic        halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DHELD, HALTED} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_dbuf;
  logic        w_latch;
  logic        w_mem_pending;
  logic        w_advance;
  logic        w_lu;

  assign w_mem_pending = mem_dREN | mem_dWEN;
  assign w_advance = ihit & (~w_mem_pending | dhit | (r_state == DHELD))
                     & (r_state != HALTED);
  assign w_lu = ex_dREN & ex_rfWEN & (ex_wsel != 5'd0) &
                ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_dbuf  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_dbuf <= dload_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    unique case (r_state)
      RUN: begin
        if (wb_halt & w_advance) begin
          w_state_nxt = HALTED;
        end else if (dhit & w_mem_pending & ~ihit) begin
          w_state_nxt = DHELD;
          w_latch     = 1'b1;
        end
      end
      DHELD: begin
        if (wb_halt & w_advance) w_state_nxt = HALTED;
        else if (ihit)           w_state_nxt = RUN;
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    if (w_advance) begin
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      idex_en  = 1'b1;
      if (br_mispredict) begin
        // A wrong-path younger load must not stall the redirect.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_lu) begin
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end
  end

  // A completed access must not be reissued while the fetch side catches up.
  assign dmem_req_en = (r_state == RUN);
  assign dload_o     = (r_state == DHELD) ? r_dbuf : dload_i;
  assign halted      = (r_state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (r_state != HALTED) begin
      if (~w_advance | w_lu)        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_advance & br_mispredict) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
